// File: rtl/spi_target.sv
// spi_target: SPI mode-0 target (MSB first) with a one-byte TX holding buffer
// and a one-byte RX output register. All SPI pins are oversampled in the clk
// domain, so clk must run at least 8x the SCLK frequency.
// Optional build macro SPI_TARGET_ERRFLAGS_EN adds sticky overrun/underrun
// flags and their err_clr input.
module spi_target #(
  parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_cs_n,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       busy
`ifdef SPI_TARGET_ERRFLAGS_EN
  ,
  output logic       overrun,
  output logic       underrun,
  input  logic       err_clr
`endif
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  // pin synchronizers plus one registered copy for edge detection
  logic       cs_meta, cs_sync, cs_q;
  logic       sclk_meta, sclk_sync, sclk_q;
  logic       mosi_meta, mosi_sync;

  // after reset the synchronizers hold forced idle levels; settle_pipe marks
  // when they carry real pin values again, and armed records that chip
  // select has been seen high since then, so a select that was already low
  // across reset is never mistaken for a fresh fall
  logic [2:0] settle_pipe;
  logic       armed;

  state_t     state;
  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [7:0] tx_shift;
  logic       buf_full;
  logic [7:0] buf_data;

  logic       cs_fall, cs_rise, sclk_rise, sclk_fall;
  logic       start_sel, boundary, reload_now, byte_done, load_idle;
  logic [7:0] load_byte, rx_byte;

  assign cs_fall   = cs_q & ~cs_sync;
  assign cs_rise   = ~cs_q & cs_sync;
  assign sclk_rise = sclk_sync & ~sclk_q;
  assign sclk_fall = ~sclk_sync & sclk_q;

  // a chip-select rise outranks any SCLK edge detected in the same cycle
  assign start_sel  = (state == IDLE) & armed & cs_fall;
  assign boundary   = (state == ACTIVE) & ~cs_rise & sclk_fall & (bit_cnt == 3'd0);
  assign reload_now = start_sel | boundary;
  assign byte_done  = (state == ACTIVE) & ~cs_rise & sclk_rise & (bit_cnt == 3'd7);

  // reload source: held byte first, else a byte offered this very cycle
  // (bypass, buffer stays empty), else the idle filler
  assign load_byte = buf_full ? buf_data : (tx_valid ? tx_data : IDLE_BYTE);
  assign load_idle = ~buf_full & ~tx_valid;
  assign rx_byte   = {rx_shift, mosi_sync};

  assign spi_miso = tx_shift[7];
  assign tx_ready = ~buf_full;
  assign busy     = (state == ACTIVE);

  // two-flop synchronizers, edge-detect copies and post-reset arming
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_meta     <= 1'b1;
      cs_sync     <= 1'b1;
      cs_q        <= 1'b1;
      sclk_meta   <= 1'b0;
      sclk_sync   <= 1'b0;
      sclk_q      <= 1'b0;
      mosi_meta   <= 1'b0;
      mosi_sync   <= 1'b0;
      settle_pipe <= '0;
      armed       <= 1'b0;
    end else begin
      cs_meta     <= spi_cs_n;
      cs_sync     <= cs_meta;
      cs_q        <= cs_sync;
      sclk_meta   <= spi_sclk;
      sclk_sync   <= sclk_meta;
      sclk_q      <= sclk_sync;
      mosi_meta   <= spi_mosi;
      mosi_sync   <= mosi_meta;
      settle_pipe <= {settle_pipe[1:0], 1'b1};
      if (settle_pipe[2] && cs_sync && cs_q)
        armed <= 1'b1;
    end
  end

  // selection FSM with bit counter, shift registers, RX handshake and TX buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      rx_shift <= '0;
      tx_shift <= 8'hFF;
      miso_oe  <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      buf_full <= 1'b0;
      buf_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_sel) begin
            state    <= ACTIVE;
            bit_cnt  <= '0;
            tx_shift <= load_byte;
            miso_oe  <= 1'b1;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            // partial byte is simply dropped; the TX buffer is untouched
            state   <= IDLE;
            bit_cnt <= '0;
            miso_oe <= 1'b0;
          end else if (sclk_rise) begin
            rx_shift <= rx_byte[6:0];
            bit_cnt  <= bit_cnt + 3'd1;
          end else if (sclk_fall) begin
            if (bit_cnt != 3'd0)
              tx_shift <= {tx_shift[6:0], 1'b1};
            else
              tx_shift <= load_byte;
          end
        end
        default: state <= IDLE;
      endcase

      // a completing byte beats a same-cycle acknowledge
      if (byte_done) begin
        rx_data  <= rx_byte;
        rx_valid <= 1'b1;
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end

      // a reload drains the buffer; when it was empty a same-cycle write is
      // consumed by the reload itself and never lands in the buffer
      if (reload_now) begin
        buf_full <= 1'b0;
      end else if (tx_valid && !buf_full) begin
        buf_full <= 1'b1;
        buf_data <= tx_data;
      end
    end
  end

`ifdef SPI_TARGET_ERRFLAGS_EN
  // sticky error flags; a same-cycle set wins over err_clr
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (err_clr) begin
        overrun  <= 1'b0;
        underrun <= 1'b0;
      end
      if (byte_done && rx_valid && !rx_ack)
        overrun <= 1'b1;
      if (boundary && load_idle)
        underrun <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target: directed bench for spi_target. The master task bit-bangs
// SCLK at clk/8 and returns the byte read on MISO; expected RX bytes go into
// a queue that a separate monitor pops (and acknowledges) as rx_valid shows.
module tb_spi_target;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       spi_cs_n = 1'b1;
  logic       spi_sclk = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_miso, miso_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack = 1'b0;
  logic       busy;
`ifdef SPI_TARGET_ERRFLAGS_EN
  logic       overrun, underrun;
  logic       err_clr = 1'b0;
`endif

  spi_target #(.IDLE_BYTE(8'hFF)) dut (
    .clk      (clk),
    .rst      (rst),
    .spi_cs_n (spi_cs_n),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .miso_oe  (miso_oe),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ack   (rx_ack),
    .busy     (busy)
`ifdef SPI_TARGET_ERRFLAGS_EN
    ,
    .overrun  (overrun),
    .underrun (underrun),
    .err_clr  (err_clr)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_tests = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  bit         auto_ack = 1'b1;
  int         rise_cyc = 0;
  int         seen_cyc = -1;
  logic [7:0] rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: every presented RX byte is compared, then acked
  initial begin
    forever begin
      @(negedge clk);
      if (rx_ack) begin
        rx_ack = 1'b0;
      end else if (rx_valid && auto_ack) begin
        seen_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rx_unexpected: got %0h, expected no byte", rx_data);
        end else begin
          check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
        end
        rx_ack = 1'b1;
      end
    end
  end

  // mode-0 master: nbits bits MSB first, 4 clk per SCLK half period; the
  // optional bypass offers a TX byte exactly at the trailing-fall reload
  task automatic xfer(input logic [7:0] mo, input int nbits, input bit byp,
                      input logic [7:0] byp_data, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = mo[i];
      repeat (4) @(negedge clk);
      mi[i] = spi_miso;
      spi_sclk = 1'b1;
      rise_cyc = cyc;
      repeat (4) @(negedge clk);
      spi_sclk = 1'b0;
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (byp && k == 2) begin
        tx_data  = byp_data;
        tx_valid = 1'b1;
      end
      if (byp && k == 3) begin
        check("bypass_tx_ready", 32'(tx_ready), 1);
        tx_valid = 1'b0;
      end
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d bytes still pending, expected 0", name, exp_q.size());
    end
  endtask

  task automatic select(input logic lvl, input int settle);
    spi_cs_n = lvl;
    repeat (settle) @(negedge clk);
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check("rst_miso", 32'(spi_miso), 1);
    check("rst_oe", 32'(miso_oe), 0);
    check("rst_tx_ready", 32'(tx_ready), 1);
    check("rst_rx_valid", 32'(rx_valid), 0);
    check("rst_rx_data", 32'(rx_data), 0);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // preloaded A5 out, 3C in, latency from the 8th rise
    tx_data = 8'hA5; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("t1_tx_full", 32'(tx_ready), 0);
    select(1'b0, 6);
    check("t1_busy", 32'(busy), 1);
    check("t1_oe", 32'(miso_oe), 1);
    check("t1_buf_drained", 32'(tx_ready), 1);
    exp_q.push_back(8'h3C);
    seen_cyc = -1;
    xfer(8'h3C, 8, 1'b0, 8'h00, rd);
    check("t1_miso", 32'(rd), 'hA5);
    check("t1_latency", 32'(seen_cyc - rise_cyc), 3);
    select(1'b1, 6);
    check("t1_idle_busy", 32'(busy), 0);
    check("t1_idle_oe", 32'(miso_oe), 0);

    // nothing queued: idle filler on both bytes
    select(1'b0, 6);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    xfer(8'h01, 8, 1'b0, 8'h00, rd);
    check("t2_miso0", 32'(rd), 'hFF);
    xfer(8'h02, 8, 1'b0, 8'h00, rd);
    check("t2_miso1", 32'(rd), 'hFF);
`ifdef SPI_TARGET_ERRFLAGS_EN
    check("t2_underrun", 32'(underrun), 1);
`endif
    select(1'b1, 6);
    drain("t2_drain");

    // two bytes with no ack: second overwrites
    auto_ack = 1'b0;
    select(1'b0, 6);
    xfer(8'h11, 8, 1'b0, 8'h00, rd);
    xfer(8'h22, 8, 1'b0, 8'h00, rd);
    repeat (4) @(negedge clk);
    check("t3_rx_valid", 32'(rx_valid), 1);
    check("t3_rx_data", 32'(rx_data), 'h22);
`ifdef SPI_TARGET_ERRFLAGS_EN
    check("t3_overrun", 32'(overrun), 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("t3_overrun_clr", 32'(overrun), 0);
    check("t3_underrun_clr", 32'(underrun), 0);
`endif
    select(1'b1, 6);
    exp_q.push_back(8'h22);
    auto_ack = 1'b1;
    drain("t3_drain");

    // abort after 5 rises, then a clean C3
    select(1'b0, 6);
    xfer(8'hF0, 5, 1'b0, 8'h00, rd);
    select(1'b1, 8);
    check("t4_no_rx", 32'(rx_valid), 0);
    check("t4_oe", 32'(miso_oe), 0);
    check("t4_busy", 32'(busy), 0);
    select(1'b0, 6);
    exp_q.push_back(8'hC3);
    xfer(8'hC3, 8, 1'b0, 8'h00, rd);
    select(1'b1, 6);
    drain("t4_drain");

    // write offered exactly at the boundary reload goes straight out
    select(1'b0, 6);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    xfer(8'h00, 8, 1'b1, 8'h5A, rd);
    check("t5_miso0", 32'(rd), 'hFF);
    xfer(8'h00, 8, 1'b0, 8'h00, rd);
    check("t5_miso1", 32'(rd), 'h5A);
    check("t5_tx_ready", 32'(tx_ready), 1);
    select(1'b1, 6);
    drain("t5_drain");

    // reset mid-byte with chip select held low
    select(1'b0, 6);
    xfer(8'hAA, 4, 1'b0, 8'h00, rd);
    rst = 1'b1;
    @(negedge clk);
    check("t6_miso", 32'(spi_miso), 1);
    check("t6_oe", 32'(miso_oe), 0);
    check("t6_tx_ready", 32'(tx_ready), 1);
    check("t6_rx_valid", 32'(rx_valid), 0);
    check("t6_rx_data", 32'(rx_data), 0);
    check("t6_busy", 32'(busy), 0);
`ifdef SPI_TARGET_ERRFLAGS_EN
    check("t6_underrun", 32'(underrun), 0);
`endif
    rst = 1'b0;
    xfer(8'h55, 8, 1'b0, 8'h00, rd);
    repeat (6) @(negedge clk);
    check("t6_post_busy", 32'(busy), 0);
    check("t6_post_rx", 32'(rx_valid), 0);
    check("t6_post_oe", 32'(miso_oe), 0);
    select(1'b1, 8);
    select(1'b0, 6);
    exp_q.push_back(8'h96);
    xfer(8'h96, 8, 1'b0, 8'h00, rd);
    select(1'b1, 6);
    drain("t6_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
